// File: rtl/bird_pkg.sv
// Shared types and board defaults for the bird column driver.
package bird_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLY  = 2'd1,
    DEAD = 2'd2
  } bird_state_t;

  localparam int DEF_ROWS        = 8;
  localparam int DEF_START_ROW   = 4;
  localparam int DEF_FALL_PERIOD = 25_000_000;

  // Width of a row index; never below one bit.
  function automatic int ROW_W(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/key_sync_edge.sv
// Two-flop synchronizer on an active-low key plus a press (falling-edge) detector.
module key_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Released key reads as 1 in every stage after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign press = (~sync2_q) & prev_q;

endmodule

// File: rtl/bird_motion_ctrl.sv
// Flap/gravity pulse generator for the bird column with row tracking and crash detection.
module bird_motion_ctrl
  import bird_pkg::*;
#(
  parameter int ROWS        = DEF_ROWS,
  parameter int START_ROW   = DEF_START_ROW,
  parameter int FALL_PERIOD = DEF_FALL_PERIOD
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     key_n,
  input  logic                     game_over,
  output logic                     button,
  output logic                     fall,
  output logic [ROW_W(ROWS)-1:0]   bird_row,
  output logic                     alive,
  output logic                     crashed
);

  localparam int RW = ROW_W(ROWS);
  localparam int CW = (FALL_PERIOD > 2) ? $clog2(FALL_PERIOD) : 1;

  localparam logic [RW-1:0] ROW_ZERO  = {RW{1'b0}};
  localparam logic [RW-1:0] ROW_ONE   = RW'(1);
  localparam logic [RW-1:0] ROW_TOP   = RW'(ROWS - 1);
  localparam logic [RW-1:0] ROW_START = RW'(START_ROW);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(FALL_PERIOD - 1);

  bird_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] row_q, row_d;
  logic          button_q, button_d;
  logic          fall_q, fall_d;
  logic          alive_q, crashed_q;
  logic          press;

  key_sync_edge u_key (
    .clk   (clk),
    .reset (reset),
    .key_n (key_n),
    .press (press)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= CNT_ZERO;
      row_q     <= ROW_START;
      button_q  <= 1'b0;
      fall_q    <= 1'b0;
      alive_q   <= 1'b0;
      crashed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      button_q  <= button_d;
      fall_q    <= fall_d;
      alive_q   <= (state_d == FLY);
      crashed_q <= (state_d == DEAD);
    end
  end

  // Priority in FLY: collision, then press, then gravity terminal count.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    row_d    = row_q;
    button_d = 1'b0;
    fall_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = CNT_ZERO;
        row_d = ROW_START;
        if (press) begin
          state_d = FLY;
        end else begin
          state_d = IDLE;
        end
      end
      FLY: begin
        if (game_over) begin
          state_d = DEAD;
        end else if (press) begin
          cnt_d = CNT_ZERO;
          if (row_q < ROW_TOP) begin
            button_d = 1'b1;
            row_d    = row_q + ROW_ONE;
          end else begin
            row_d = row_q;
          end
        end else if (cnt_q == CNT_LAST) begin
          if (row_q != ROW_ZERO) begin
            fall_d = 1'b1;
            row_d  = row_q - ROW_ONE;
            cnt_d  = CNT_ZERO;
          end else begin
            state_d = DEAD;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DEAD: begin
        state_d = DEAD;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign button   = button_q;
  assign fall     = fall_q;
  assign bird_row = row_q;
  assign alive    = alive_q;
  assign crashed  = crashed_q;

endmodule

// File: tb/tb_bird_motion_ctrl.sv
// Scoreboard bench: a cycle-level reference model queues expected outputs, a monitor compares them.
module tb_bird_motion_ctrl;

  localparam int ROWS = 8;
  localparam int START_ROW = 4;
  localparam int FALL_PERIOD = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_n;
  logic       game_over;
  logic       button;
  logic       fall;
  logic [2:0] bird_row;
  logic       alive;
  logic       crashed;

  int tests = 0;
  int fails = 0;
  logic done = 1'b0;
  logic [6:0] exp_q[$];

  bird_motion_ctrl #(
    .ROWS        (ROWS),
    .START_ROW   (START_ROW),
    .FALL_PERIOD (FALL_PERIOD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key_n     (key_n),
    .game_over (game_over),
    .button    (button),
    .fall      (fall),
    .bird_row  (bird_row),
    .alive     (alive),
    .crashed   (crashed)
  );

  always #5 clk = ~clk;

  // Reference model: mode, row and the cycle of the last flap/fall/start event.
  localparam int M_IDLE = 0;
  localparam int M_FLY  = 1;
  localparam int M_DEAD = 2;

  initial begin
    int mode, row, now, last_evt;
    logic h0, h1, h2, h3, pe, bt, fl;
    mode = M_IDLE; row = START_ROW; now = 0; last_evt = 0;
    h0 = 1'b1; h1 = 1'b1; h2 = 1'b1; h3 = 1'b1;
    forever begin
      @(posedge clk);
      now = now + 1;
      h3 = h2; h2 = h1; h1 = h0; h0 = key_n;
      pe = (h2 == 1'b0) && (h3 == 1'b1);
      bt = 1'b0;
      fl = 1'b0;
      if (reset) begin
        mode = M_IDLE;
        row  = START_ROW;
        h0 = 1'b1; h1 = 1'b1; h2 = 1'b1;
      end else if (mode == M_IDLE) begin
        row = START_ROW;
        if (pe) begin
          mode = M_FLY;
          last_evt = now;
        end
      end else if (mode == M_FLY) begin
        if (game_over) begin
          mode = M_DEAD;
        end else if (pe) begin
          last_evt = now;
          if (row < ROWS - 1) begin
            row = row + 1;
            bt = 1'b1;
          end
        end else if (now - last_evt == FALL_PERIOD) begin
          if (row > 0) begin
            row = row - 1;
            fl = 1'b1;
            last_evt = now;
          end else begin
            mode = M_DEAD;
          end
        end
      end
      exp_q.push_back({bt, fl, 3'(row), (mode == M_FLY), (mode == M_DEAD)});
    end
  end

  // Monitor: one expected record per clock, compared away from the active edge.
  initial begin
    logic [6:0] exp_v;
    logic [6:0] got_v;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        got_v = {button, fall, bird_row, alive, crashed};
        tests = tests + 1;
        if (got_v !== exp_v) begin
          fails = fails + 1;
          $display("FAIL outputs @%0t: got btn=%0b fall=%0b row=%0d alive=%0b crashed=%0b, expected btn=%0b fall=%0b row=%0d alive=%0b crashed=%0b",
                   $time, got_v[6], got_v[5], got_v[4:2], got_v[1], got_v[0],
                   exp_v[6], exp_v[5], exp_v[4:2], exp_v[1], exp_v[0]);
        end
      end
    end
  end

  // Watchdog: the stimulus must complete within a bounded time.
  initial begin
    fork
      wait (done == 1'b1);
      #2_000_000;
    join_any
    tests = tests + 1;
    if (done !== 1'b1) begin
      fails = fails + 1;
      $display("FAIL timeout @%0t: stimulus did not complete", $time);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
  endtask

  task automatic press(input int hold, input int gap);
    key_n = 1'b0;
    cyc(hold);
    key_n = 1'b1;
    cyc(gap);
  endtask

  initial begin
    reset = 1'b1;
    key_n = 1'b1;
    game_over = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(50);

    tests = tests + 1;
    if ((button !== 1'b0) || (fall !== 1'b0) || (bird_row !== 3'(START_ROW)) ||
        (alive !== 1'b0) || (crashed !== 1'b0)) begin
      fails = fails + 1;
      $display("FAIL idle state @%0t: btn=%0b fall=%0b row=%0d alive=%0b crashed=%0b",
               $time, button, fall, bird_row, alive, crashed);
    end

    // Start, free fall to the ground, then presses in DEAD are ignored.
    press(2, 50);
    press(3, 5);
    do_reset();
    cyc(3);

    // Second press at various counter phases, including terminal count.
    for (int g = 4; g <= 10; g++) begin
      press(2, g);
      press(2, 12);
      do_reset();
    end

    // Four quick presses from row 4: saturate at the top row.
    press(2, 3);
    for (int i = 0; i < 4; i++) begin
      press(1, 2);
    end
    cyc(4);
    do_reset();

    // Held key gives a single flap.
    press(2, 3);
    press(100, 5);
    do_reset();

    // One-cycle collision, then reset mid-FLY.
    press(2, 5);
    game_over = 1'b1;
    cyc(1);
    game_over = 1'b0;
    cyc(12);
    do_reset();
    press(2, 5);
    do_reset();
    cyc(2);

    // Randomized mix of presses, collisions and resets.
    for (int i = 0; i < 80; i++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) begin
        do_reset();
      end else if (r == 1) begin
        game_over = 1'b1;
        cyc(1);
        game_over = 1'b0;
      end else begin
        press($urandom_range(1, 4), $urandom_range(1, 12));
      end
    end
    cyc(3);

    done = 1'b1;
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
